selection_credit_port: RTL and testbench
========================================

# selection_credit_port

Output-port selection stage that consumes the routing unit's per-input candidate lists (`o_select_neighbor` / `o_avail_directions`) and commits each input to exactly one output port. It sits between routing computation and switch allocation. When there are two candidates, it picks the neighbour with more downstream credits and breaks ties round-robin. It holds a one-hot output request per input until the switch allocator grants it.

## Interface
Parameters:
- `CREDIT_W`, default 3: width of each downstream credit count.

Ports (`N`, `M`, `X_NODES` and `Y_NODES` come from config.sv):
- `clk`  in  1  system clock
- `reset`  in  1  asynchronous, active-high reset; one clock domain only
- `i_select_neighbor`  in  [0:`N-1]  per-input candidate-list valid, from routing
- `i_avail_directions`  in  [0:`N-1][0:`M-1][1:0]  candidate directions; slot `M-1` holds the candidate count
- `i_credit`  in  [0:`N-1][CREDIT_W-1:0]  free downstream slots per output port; entry 0 (local) is ignored
- `i_grant`  in  [0:`N-1]  switch-allocator grant for the pending request of each input
- `o_output_req`  out  [0:`N-1][0:`N-1]  one-hot request per input, bit order [local, north, east, south, west]
- `o_ready`  out  [0:`N-1]  input can accept a new candidate list this cycle
- `o_error`  out  [0:`N-1]  one-cycle pulse when a candidate list arrives with count 0

## Operation
- Direction codes: 0 = north, 1 = east, 2 = south, 3 = west. Code d maps to one-hot bit d+1. The local bit (bit 0) is never driven.
- Each input has an independent FSM with two states:
  - IDLE: `o_output_req[i]` = 0.
  - REQ: `o_output_req[i]` holds the chosen one-hot value.
- `o_ready[i]` = (state == IDLE) | `i_grant[i]`. This is combinational.
- A list is accepted when `i_select_neighbor[i]` & `o_ready[i]`. The count is slot `M-1`:
  - count 0: pulse `o_error[i]`; go to or stay in IDLE.
  - count 1: choose slot 0.
  - count ≥ 2: compare `i_credit` at the outputs for slot 0 and slot 1; the larger wins. On equal credits, choose slot `tb[i]` (per-input tie-break bit) and toggle `tb[i]` on acceptance. Slots beyond 1 are ignored.
- Credits are sampled only in the acceptance cycle. The choice is frozen until grant; no re-evaluation.
- A choice whose downstream credit is 0 is still requested; the allocator is responsible for gating it.
- REQ + `i_grant[i]` with no new list: go to IDLE.
- REQ + `i_grant[i]` + acceptance in the same cycle: load the new choice and stay in REQ (back-to-back, no bubble).
- REQ without grant: `i_select_neighbor[i]` is ignored and dropped. Upstream must honour `o_ready`.
- `i_grant[i]` while IDLE has no effect.

## Timing
- Reset values: all `o_output_req` = 0, `o_error` = 0, state = IDLE, `tb` = 0, so `o_ready` = all 1.
- Latency:
  - Acceptance at edge t: `o_output_req` valid from cycle t+1.
  - Grant sampled at edge t: `o_output_req` cleared in cycle t+1, unless a back-to-back load occurs.
- `o_output_req` and `o_error` are registered. `o_error` is high for exactly one cycle.
- Reset asserted mid-REQ clears everything immediately. Any pending request is lost and is not reissued.

## Structure
- Shared package `selection_pkg`:
  - direction enum (DIR_NORTH..DIR_WEST)
  - state enum {IDLE, REQ}
  - function `dir_to_onehot` (2-bit code → `N`-bit one-hot)
  - constant `CNT_SLOT` = `M-1`
- Sub-module `selection_port`: one input's FSM, comparator and tie-break bit. The top instantiates it `N` times, driving each instance with the full `i_credit` vector.

## Test plan
- Input 2, count 1, slot0 = 1 (east) → `o_output_req[2]` = 5'b00100 in the next cycle. Grant two cycles later → 0 the following cycle, `o_ready[2]` = 1.
- Input 1, candidates north/east, credit north = 1, east = 4 → 5'b00100. Swap credits and repeat → 5'b01000.
- Input 0, north/east with equal credits 3/3, twice with grants between:
  - first → 5'b01000, `tb` becomes 1
  - second → 5'b00100
- Count 0 with select → `o_error` high for one cycle, request stays 0, `o_ready` stays 1.
- Select while REQ and no grant → ignored, `o_ready` = 0, request unchanged. Grant and select in the same cycle → new request next cycle, no idle cycle.
- Assert reset while inputs 0–4 are all in REQ → all requests 0 and `o_ready` = 5'b11111 before the next edge. After release, a tie is decided by slot 0.

Source files
------------

// File: rtl/selection_pkg.sv
// rtl/selection_pkg.sv - shared types, sizes and helpers for output-port selection
package selection_pkg;

  localparam int N = 5;
  localparam int M = 3;
  localparam int X_NODES = 4;
  localparam int Y_NODES = 4;
  localparam int CNT_SLOT = M - 1;

  typedef enum logic [1:0] {
    DIR_NORTH = 2'd0,
    DIR_EAST  = 2'd1,
    DIR_SOUTH = 2'd2,
    DIR_WEST  = 2'd3
  } dir_e;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_e;

  // Direction d lands on bit d+1; bit 0 (local) is never produced here.
  function automatic logic [0:N-1] dir_to_onehot(input logic [1:0] d);
    logic [0:N-1] oh;
    oh = '0;
    oh[3'(d) + 3'd1] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/selection_port.sv
// rtl/selection_port.sv - one input's selection FSM, credit comparator and tie-break bit
module selection_port
  import selection_pkg::*;
#(
  parameter int CREDIT_W = 3
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           select,
  input  logic [0:M-1][1:0]              avail,
  input  logic [0:N-1][CREDIT_W-1:0]     credit,
  input  logic                           grant,
  output logic [0:N-1]                   req,
  output logic                           ready,
  output logic                           error
);

  state_e              state, state_n;
  logic [0:N-1]        req_n;
  logic                err_n;
  logic                tb, tb_n;
  logic                accept;
  logic [1:0]          cnt;
  logic [CREDIT_W-1:0] c0, c1;
  logic [1:0]          pick;

  assign ready  = (state == IDLE) | grant;
  assign accept = select & ready;
  assign cnt    = avail[CNT_SLOT];
  assign c0     = credit[3'(avail[0]) + 3'd1];
  assign c1     = credit[3'(avail[1]) + 3'd1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      req   <= '0;
      error <= 1'b0;
      tb    <= 1'b0;
    end else begin
      state <= state_n;
      req   <= req_n;
      error <= err_n;
      tb    <= tb_n;
    end
  end

  always_comb begin
    state_n = state;
    req_n   = req;
    err_n   = 1'b0;
    tb_n    = tb;
    pick    = avail[0];
    if (state == REQ && grant) begin
      state_n = IDLE;
      req_n   = '0;
    end
    if (accept) begin
      if (cnt == 2'd0) begin
        err_n   = 1'b1;
        state_n = IDLE;
        req_n   = '0;
      end else begin
        // Only slots 0 and 1 compete; equal credits alternate via tb.
        if (cnt >= 2'd2) begin
          if (c1 > c0) begin
            pick = avail[1];
          end else if (c1 == c0) begin
            pick = tb ? avail[1] : avail[0];
            tb_n = ~tb;
          end
        end
        state_n = REQ;
        req_n   = dir_to_onehot(pick);
      end
    end
  end

endmodule

// File: rtl/selection_credit_port.sv
// rtl/selection_credit_port.sv - commits each input to one output port using downstream credits
module selection_credit_port
  import selection_pkg::*;
#(
  parameter int CREDIT_W = 3
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [0:N-1]                   i_select_neighbor,
  input  logic [0:N-1][0:M-1][1:0]       i_avail_directions,
  input  logic [0:N-1][CREDIT_W-1:0]     i_credit,
  input  logic [0:N-1]                   i_grant,
  output logic [0:N-1][0:N-1]            o_output_req,
  output logic [0:N-1]                   o_ready,
  output logic [0:N-1]                   o_error
);

  for (genvar g = 0; g < N; g++) begin : g_port
    selection_port #(
      .CREDIT_W (CREDIT_W)
    ) u_port (
      .clk    (clk),
      .reset  (reset),
      .select (i_select_neighbor[g]),
      .avail  (i_avail_directions[g]),
      .credit (i_credit),
      .grant  (i_grant[g]),
      .req    (o_output_req[g]),
      .ready  (o_ready[g]),
      .error  (o_error[g])
    );
  end

endmodule

// File: tb/tb_selection_credit_port.sv
// tb/tb_selection_credit_port.sv - directed self-checking bench for selection_credit_port
module tb_selection_credit_port;
  import selection_pkg::*;

  localparam int CREDIT_W = 3;

  logic                       clk;
  logic                       reset;
  logic [0:N-1]               i_select_neighbor;
  logic [0:N-1][0:M-1][1:0]   i_avail_directions;
  logic [0:N-1][CREDIT_W-1:0] i_credit;
  logic [0:N-1]               i_grant;
  logic [0:N-1][0:N-1]        o_output_req;
  logic [0:N-1]               o_ready;
  logic [0:N-1]               o_error;

  int checks = 0;
  int errors = 0;

  selection_credit_port #(.CREDIT_W(CREDIT_W)) dut (
    .clk                (clk),
    .reset              (reset),
    .i_select_neighbor  (i_select_neighbor),
    .i_avail_directions (i_avail_directions),
    .i_credit           (i_credit),
    .i_grant            (i_grant),
    .o_output_req       (o_output_req),
    .o_ready            (o_ready),
    .o_error            (o_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_list(input int i, input logic [1:0] s0, input logic [1:0] s1, input logic [1:0] cnt);
    i_avail_directions[i][0]        = s0;
    i_avail_directions[i][1]        = s1;
    i_avail_directions[i][CNT_SLOT] = cnt;
    i_select_neighbor[i]            = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    i_select_neighbor = '0;
    i_avail_directions = '0;
    i_credit = '0;
    i_grant = '0;
    step();
    step();
    checks++;
    if (o_output_req !== '0) begin errors++; $display("FAIL reset_req got %h want 0", o_output_req); end
    checks++;
    if (o_ready !== 5'b11111) begin errors++; $display("FAIL reset_ready got %b want 11111", o_ready); end
    checks++;
    if (o_error !== 5'b00000) begin errors++; $display("FAIL reset_error got %b want 00000", o_error); end
    reset = 1'b0;
    step();
  endtask

  task automatic test_single();
    set_list(2, 2'd1, 2'd0, 2'd1);
    step();
    i_select_neighbor = '0;
    checks++;
    if (o_output_req[2] !== 5'b00100) begin errors++; $display("FAIL single_req got %b want 00100", o_output_req[2]); end
    checks++;
    if (o_ready[2] !== 1'b0) begin errors++; $display("FAIL single_busy got %b want 0", o_ready[2]); end
    step();
    checks++;
    if (o_output_req[2] !== 5'b00100) begin errors++; $display("FAIL single_hold got %b want 00100", o_output_req[2]); end
    i_grant[2] = 1'b1;
    #1;
    checks++;
    if (o_ready[2] !== 1'b1) begin errors++; $display("FAIL single_ready_on_grant got %b want 1", o_ready[2]); end
    step();
    i_grant = '0;
    #1;
    checks++;
    if (o_output_req[2] !== 5'b00000) begin errors++; $display("FAIL single_clear got %b want 00000", o_output_req[2]); end
    checks++;
    if (o_ready[2] !== 1'b1) begin errors++; $display("FAIL single_ready_idle got %b want 1", o_ready[2]); end
  endtask

  task automatic test_credit();
    i_credit[1] = 3'd1;
    i_credit[2] = 3'd4;
    set_list(1, 2'd0, 2'd1, 2'd2);
    step();
    i_select_neighbor = '0;
    checks++;
    if (o_output_req[1] !== 5'b00100) begin errors++; $display("FAIL credit_east got %b want 00100", o_output_req[1]); end
    i_grant[1] = 1'b1;
    step();
    i_grant = '0;
    i_credit[1] = 3'd4;
    i_credit[2] = 3'd1;
    set_list(1, 2'd0, 2'd1, 2'd2);
    step();
    i_select_neighbor = '0;
    checks++;
    if (o_output_req[1] !== 5'b01000) begin errors++; $display("FAIL credit_north got %b want 01000", o_output_req[1]); end
    i_grant[1] = 1'b1;
    step();
    i_grant = '0;
  endtask

  task automatic test_tie();
    i_credit[1] = 3'd3;
    i_credit[2] = 3'd3;
    set_list(0, 2'd0, 2'd1, 2'd2);
    step();
    i_select_neighbor = '0;
    checks++;
    if (o_output_req[0] !== 5'b01000) begin errors++; $display("FAIL tie_first got %b want 01000", o_output_req[0]); end
    i_grant[0] = 1'b1;
    step();
    i_grant = '0;
    set_list(0, 2'd0, 2'd1, 2'd2);
    step();
    i_select_neighbor = '0;
    checks++;
    if (o_output_req[0] !== 5'b00100) begin errors++; $display("FAIL tie_second got %b want 00100", o_output_req[0]); end
    i_grant[0] = 1'b1;
    step();
    i_grant = '0;
  endtask

  task automatic test_count0();
    set_list(3, 2'd2, 2'd3, 2'd0);
    step();
    i_select_neighbor = '0;
    checks++;
    if (o_error[3] !== 1'b1) begin errors++; $display("FAIL count0_error got %b want 1", o_error[3]); end
    checks++;
    if (o_output_req[3] !== 5'b00000) begin errors++; $display("FAIL count0_req got %b want 00000", o_output_req[3]); end
    checks++;
    if (o_ready[3] !== 1'b1) begin errors++; $display("FAIL count0_ready got %b want 1", o_ready[3]); end
    step();
    checks++;
    if (o_error[3] !== 1'b0) begin errors++; $display("FAIL count0_pulse got %b want 0", o_error[3]); end
  endtask

  task automatic test_back_to_back();
    set_list(4, 2'd1, 2'd0, 2'd1);
    step();
    set_list(4, 2'd3, 2'd0, 2'd1);
    #1;
    checks++;
    if (o_ready[4] !== 1'b0) begin errors++; $display("FAIL hold_ready got %b want 0", o_ready[4]); end
    step();
    checks++;
    if (o_output_req[4] !== 5'b00100) begin errors++; $display("FAIL hold_req got %b want 00100", o_output_req[4]); end
    set_list(4, 2'd0, 2'd0, 2'd1);
    i_grant[4] = 1'b1;
    step();
    i_select_neighbor = '0;
    i_grant = '0;
    #1;
    checks++;
    if (o_output_req[4] !== 5'b01000) begin errors++; $display("FAIL b2b_req got %b want 01000", o_output_req[4]); end
    checks++;
    if (o_ready[4] !== 1'b0) begin errors++; $display("FAIL b2b_ready got %b want 0", o_ready[4]); end
    i_grant[4] = 1'b1;
    step();
    i_grant = '0;
  endtask

  task automatic test_reset_mid();
    i_credit[1] = 3'd3;
    i_credit[2] = 3'd3;
    for (int i = 0; i < N; i++) set_list(i, 2'd0, 2'd1, 2'd2);
    step();
    i_select_neighbor = '0;
    checks++;
    if (o_output_req !== {N{5'b01000}}) begin errors++; $display("FAIL mid_load got %h want %h", o_output_req, {N{5'b01000}}); end
    reset = 1'b1;
    #1;
    checks++;
    if (o_output_req !== '0) begin errors++; $display("FAIL mid_reset_req got %h want 0", o_output_req); end
    checks++;
    if (o_ready !== 5'b11111) begin errors++; $display("FAIL mid_reset_ready got %b want 11111", o_ready); end
    step();
    reset = 1'b0;
    step();
    checks++;
    if (o_output_req !== '0) begin errors++; $display("FAIL mid_no_reissue got %h want 0", o_output_req); end
    set_list(0, 2'd0, 2'd1, 2'd2);
    step();
    i_select_neighbor = '0;
    checks++;
    if (o_output_req[0] !== 5'b01000) begin errors++; $display("FAIL mid_tb_cleared got %b want 01000", o_output_req[0]); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_credit();
    test_tie();
    test_count0();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
